// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong bank-ownership controller:
// bank-state encoding, default address width and the frame-length clamp.
package pingpong_pkg;

  localparam logic BANK_EMPTY = 1'b0;
  localparam logic BANK_FULL  = 1'b1;

  localparam int DEF_ADDR_W = 7;

  // A bank holds at most 2^addr_w bytes; longer reported lengths saturate.
  function automatic logic [31:0] len_clamp(input logic [31:0] len,
                                            input int unsigned addr_w);
    logic [31:0] limit;
    limit = 32'd1 << addr_w;
    return (len > limit) ? limit : len;
  endfunction

endpackage

// File: rtl/pingpong_bank_ctrl_sat_cnt8.sv
// 8-bit saturating event counter with synchronous clear; clear wins over inc.
module sat_cnt8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// Two-bank ping-pong ownership controller: tracks EMPTY/FULL per bank, steers
// producer and consumer, latches frame lengths and flags protocol violations.
// Build option: define PINGPONG_ERR_CNT_EN to get saturating error counters.
module pingpong_bank_ctrl
  import pingpong_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_finish,
  input  logic [LEN_W-1:0] wr_len,
  output logic             wr_ready,
  output logic             wr_bank,
  input  logic             rd_finish,
  output logic             rd_ready,
  output logic             rd_bank,
  output logic [LEN_W-1:0] rd_len,
  output logic [1:0]       frames,
  input  logic             err_clr,
  output logic             wr_ovr,
  output logic             rd_udr,
  output logic [7:0]       wr_ovr_cnt,
  output logic [7:0]       rd_udr_cnt
);

  // Handshake: a finish pulse is accepted only when the matching ready is
  // high at that edge; otherwise it is rejected, changes no bank state and
  // is recorded as an error. Ready/bank outputs depend only on registered
  // state, so the producer/consumer see the result one cycle later.

  logic [1:0]       bank_q;
  logic             wp_q;
  logic             rp_q;
  logic [LEN_W-1:0] len_q [2];

  logic             wr_acc;
  logic             wr_rej;
  logic             rd_acc;
  logic             rd_rej;
  logic [LEN_W-1:0] len_in;

  assign wr_ready = (bank_q[wp_q] == BANK_EMPTY);
  assign wr_bank  = wp_q;
  assign rd_ready = (bank_q[rp_q] == BANK_FULL);
  assign rd_bank  = rp_q;
  assign rd_len   = len_q[rp_q];
  assign frames   = {1'b0, bank_q[0]} + {1'b0, bank_q[1]};

  assign wr_acc = wr_finish &  wr_ready;
  assign wr_rej = wr_finish & ~wr_ready;
  assign rd_acc = rd_finish &  rd_ready;
  assign rd_rej = rd_finish & ~rd_ready;

  assign len_in = LEN_W'(len_clamp(32'(wr_len), ADDR_W));

  // A write needs bank[wp] EMPTY and a read needs bank[rp] FULL, so the two
  // acceptances never target the same bank in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q   <= {BANK_EMPTY, BANK_EMPTY};
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      len_q[0] <= '0;
      len_q[1] <= '0;
    end else begin
      if (wr_acc) begin
        bank_q[wp_q] <= BANK_FULL;
        len_q[wp_q]  <= len_in;
        wp_q         <= ~wp_q;
      end
      if (rd_acc) begin
        bank_q[rp_q] <= BANK_EMPTY;
        rp_q         <= ~rp_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ovr <= 1'b0;
      rd_udr <= 1'b0;
    end else if (err_clr) begin
      wr_ovr <= 1'b0;
      rd_udr <= 1'b0;
    end else begin
      if (wr_rej) wr_ovr <= 1'b1;
      if (rd_rej) rd_udr <= 1'b1;
    end
  end

`ifdef PINGPONG_ERR_CNT_EN
  sat_cnt8 u_wr_ovr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (err_clr),
    .inc   (wr_rej),
    .count (wr_ovr_cnt)
  );

  sat_cnt8 u_rd_udr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (err_clr),
    .inc   (rd_rej),
    .count (rd_udr_cnt)
  );
`else
  assign wr_ovr_cnt = 8'd0;
  assign rd_udr_cnt = 8'd0;
`endif

endmodule
